// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
// fetch_stage_if : word-read bus between the fetch stage and the memory controller
// Revision 1.0
// ============================================================================
interface fetch_stage_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_inst;

  modport master (output mem_req, mem_addr, input mem_ack, mem_inst);
  modport slave  (input mem_req, mem_addr, output mem_ack, mem_inst);
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// fetch_stage : PC owner with direct-mapped icache, miss handshake and registered decode handoff
// Revision 1.0
// ============================================================================
module fetch_stage #(
  parameter logic [31:0] RESET_PC     = 32'h0,
  parameter int          ICACHE_LINES = 128,
  parameter int          IDX_W        = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [31:0]          pc_if,
  input  logic                 pre_jmp_status,
  input  logic [31:0]          pre_jmp_target,
  fetch_stage_if.master        mem,
  input  logic                 stall_in,
  input  logic                 flush,
  input  logic [31:0]          flush_pc,
  output logic                 inst_valid,
  output logic [31:0]          inst_out,
  output logic [31:0]          inst_pc,
  output logic                 inst_pre_jmp
);

  localparam int TAG_W = 32 - IDX_W - 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic [31:0] pc_nxt;
  logic        req;
  logic        req_nxt;
  logic [31:0] addr;
  logic [31:0] addr_nxt;
  logic        valid_nxt;
  logic [31:0] inst_nxt;
  logic [31:0] ipc_nxt;
  logic        jmp_nxt;
  logic        fill;

  logic [ICACHE_LINES-1:0] line_valid;
  logic [TAG_W-1:0]        tag_mem  [ICACHE_LINES];
  logic [31:0]             data_mem [ICACHE_LINES];

  logic [IDX_W-1:0] look_idx;
  logic [TAG_W-1:0] look_tag;
  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;
  logic             hit;

  assign look_idx = pc[IDX_W+1:2];
  assign look_tag = pc[31:IDX_W+2];
  // The fill is addressed by the held request, not the PC, which a flush may have moved.
  assign fill_idx = addr[IDX_W+1:2];
  assign fill_tag = addr[31:IDX_W+2];
  assign hit      = line_valid[look_idx] && (tag_mem[look_idx] == look_tag);

  assign pc_if        = pc;
  assign mem.mem_req  = req;
  assign mem.mem_addr = addr;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    req_nxt   = req;
    addr_nxt  = addr;
    valid_nxt = inst_valid;
    inst_nxt  = inst_out;
    ipc_nxt   = inst_pc;
    jmp_nxt   = inst_pre_jmp;
    fill      = 1'b0;

    case (state)
      ST_IDLE: begin
        if (flush) begin
          pc_nxt    = flush_pc;
          valid_nxt = 1'b0;
        end else if (hit) begin
          if (!stall_in) begin
            valid_nxt = 1'b1;
            inst_nxt  = data_mem[look_idx];
            ipc_nxt   = pc;
            jmp_nxt   = pre_jmp_status;
            pc_nxt    = pre_jmp_status ? pre_jmp_target : pc + 32'd4;
          end
        end else begin
          state_nxt = ST_WAIT;
          req_nxt   = 1'b1;
          addr_nxt  = pc;
          if (!stall_in) begin
            valid_nxt = 1'b0;
          end
        end
      end

      ST_WAIT, ST_DRAIN: begin
        if (mem.mem_ack) begin
          fill      = 1'b1;
          req_nxt   = 1'b0;
          state_nxt = ST_IDLE;
        end else if (flush) begin
          state_nxt = ST_DRAIN;
        end
        if (flush) begin
          pc_nxt    = flush_pc;
          valid_nxt = 1'b0;
        end else if (!stall_in) begin
          valid_nxt = 1'b0;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      pc           <= RESET_PC;
      req          <= 1'b0;
      addr         <= 32'h0;
      inst_valid   <= 1'b0;
      inst_out     <= 32'h0;
      inst_pc      <= 32'h0;
      inst_pre_jmp <= 1'b0;
      line_valid   <= '0;
    end else begin
      state        <= state_nxt;
      pc           <= pc_nxt;
      req          <= req_nxt;
      addr         <= addr_nxt;
      inst_valid   <= valid_nxt;
      inst_out     <= inst_nxt;
      inst_pc      <= ipc_nxt;
      inst_pre_jmp <= jmp_nxt;
      if (fill) begin
        line_valid[fill_idx] <= 1'b1;
      end
    end
  end

  // Tag and data need no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= mem.mem_inst;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// tb_fetch_stage : directed scenarios then random fetch traffic against a transaction-level model
// Revision 1.0
// ============================================================================
module tb_fetch_stage;
  localparam int IDX_W = 7;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc_if;
  logic        pre_jmp_status = 1'b0;
  logic [31:0] pre_jmp_target = 32'h0;
  logic        stall_in = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = 32'h0;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        inst_pre_jmp;

  fetch_stage_if mif ();

  fetch_stage #(.RESET_PC(32'h0), .ICACHE_LINES(128), .IDX_W(IDX_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_if          (pc_if),
    .pre_jmp_status (pre_jmp_status),
    .pre_jmp_target (pre_jmp_target),
    .mem            (mif.master),
    .stall_in       (stall_in),
    .flush          (flush),
    .flush_pc       (flush_pc),
    .inst_valid     (inst_valid),
    .inst_out       (inst_out),
    .inst_pc        (inst_pc),
    .inst_pre_jmp   (inst_pre_jmp)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Model: architectural PC, the outstanding miss and the set of cached word addresses.
  logic [31:0] m_pc;
  logic        m_busy;
  logic        m_req;
  logic [31:0] m_addr;
  logic        m_ivalid;
  logic [31:0] m_iout;
  logic [31:0] m_ipc;
  logic        m_ijmp;
  logic [31:0] m_line [int];

  int  wait_cnt  = 0;
  int  ack_delay = 3;
  bit  rand_mode = 1'b0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  function automatic int line_idx(input logic [31:0] a);
    return int'(a[IDX_W+1:2]);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_busy = 1'b0; m_req = 1'b0; m_addr = 32'h0;
    m_ivalid = 1'b0; m_iout = 32'h0; m_ipc = 32'h0; m_ijmp = 1'b0;
    m_line.delete();
  endtask

  task automatic model_step();
    int   idx;
    logic hit;
    idx = line_idx(m_pc);
    hit = m_line.exists(idx) && (m_line[idx][31:2] == m_pc[31:2]);
    if (m_busy) begin
      if (mif.mem_ack) begin
        m_line[line_idx(m_addr)] = m_addr;
        m_req  = 1'b0;
        m_busy = 1'b0;
      end
      if (flush) begin
        m_pc = flush_pc; m_ivalid = 1'b0;
      end else if (!stall_in) begin
        m_ivalid = 1'b0;
      end
    end else if (flush) begin
      m_pc = flush_pc; m_ivalid = 1'b0;
    end else if (hit) begin
      if (!stall_in) begin
        m_ivalid = 1'b1;
        m_iout   = word_of(m_line[idx]);
        m_ipc    = m_pc;
        m_ijmp   = pre_jmp_status;
        m_pc     = pre_jmp_status ? pre_jmp_target : m_pc + 32'd4;
      end
    end else begin
      m_busy = 1'b1; m_req = 1'b1; m_addr = m_pc;
      if (!stall_in) m_ivalid = 1'b0;
    end
  endtask

  task automatic compare_all();
    check("pc_if", pc_if, m_pc);
    check("mem_req", 32'(mif.mem_req), 32'(m_req));
    check("mem_addr", mif.mem_addr, m_addr);
    check("inst_valid", 32'(inst_valid), 32'(m_ivalid));
    if (m_ivalid) begin
      check("inst_out", inst_out, m_iout);
      check("inst_pc", inst_pc, m_ipc);
      check("inst_pre_jmp", 32'(inst_pre_jmp), 32'(m_ijmp));
    end
  endtask

  task automatic drive_mem();
    if (mif.mem_ack) begin
      mif.mem_ack  = 1'b0;
      mif.mem_inst = $urandom;
      wait_cnt     = 0;
      ack_delay    = rand_mode ? int'($urandom_range(0, 4)) : 3;
    end else if (mif.mem_req) begin
      if (wait_cnt >= ack_delay) begin
        mif.mem_ack  = 1'b1;
        mif.mem_inst = word_of(mif.mem_addr);
      end else begin
        wait_cnt++;
      end
    end
  endtask

  task automatic tick();
    drive_mem();
    @(posedge clk);
    if (rst) model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic flush_to(input logic [31:0] target);
    flush = 1'b1; flush_pc = target;
    tick();
    flush = 1'b0;
  endtask

  // Reset lands between edges so its asynchronous effect is visible before any clock.
  task automatic do_reset();
    #2;
    rst = 1'b0;
    mif.mem_ack = 1'b0;
    wait_cnt = 0;
    model_reset();
    #1;
    check("rst_mem_req", 32'(mif.mem_req), 32'h0);
    check("rst_mem_addr", mif.mem_addr, 32'h0);
    check("rst_inst_valid", 32'(inst_valid), 32'h0);
    check("rst_inst_out", inst_out, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);
    check("rst_inst_pre_jmp", 32'(inst_pre_jmp), 32'h0);
    check("rst_pc_if", pc_if, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r;
    mif.mem_ack = 1'b0;
    mif.mem_inst = 32'h0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_init_inst_valid", 32'(inst_valid), 32'h0);
    check("rst_init_mem_req", 32'(mif.mem_req), 32'h0);
    rst = 1'b1;
    compare_all();

    // Cold miss at 0, ack after three waiting cycles, then the hit
    repeat (6) tick();
    check("t1_inst_out", inst_out, 32'h0000_0013);
    check("t1_inst_pc", inst_pc, 32'h0);
    check("t1_pc_if", pc_if, 32'h4);

    // Run to a miss on 0x18; the redirect coincides with its ack
    repeat (34) tick();
    flush_to(32'h0);
    for (int k = 0; k < 7; k++) begin
      tick();
      check("t2_stream_pc", inst_pc, 32'(k * 4));
    end

    // Predicted-taken hit
    flush_to(32'h10);
    pre_jmp_status = 1'b1; pre_jmp_target = 32'h40;
    tick();
    pre_jmp_status = 1'b0; pre_jmp_target = 32'h0;
    check("t3_inst_pc", inst_pc, 32'h10);
    check("t3_pre_jmp", 32'(inst_pre_jmp), 32'h1);
    check("t3_pc_if", pc_if, 32'h40);

    // Flush while waiting on 0x20
    flush_to(32'h20);
    tick();
    flush_to(32'h80);
    repeat (9) tick();
    check("t4_redirect_pc", inst_pc, 32'h80);
    flush_to(32'h20);
    tick();
    check("t4_line_filled_valid", 32'(inst_valid), 32'h1);
    check("t4_line_filled_pc", inst_pc, 32'h20);

    // Stall during hits
    flush_to(32'h0);
    tick();
    stall_in = 1'b1; pre_jmp_status = 1'b1; pre_jmp_target = 32'h200;
    repeat (4) begin
      tick();
      check("t5_pc_frozen", pc_if, 32'h4);
      check("t5_inst_pc_frozen", inst_pc, 32'h0);
    end
    stall_in = 1'b0; pre_jmp_status = 1'b0; pre_jmp_target = 32'h0;
    tick();
    check("t5_resume_pc4", inst_pc, 32'h4);
    tick();
    check("t5_resume_pc8", inst_pc, 32'h8);

    // Asynchronous reset while a miss is outstanding
    flush_to(32'h300);
    tick();
    tick();
    do_reset();
    tick();
    check("t6_refetch_miss", 32'(mif.mem_req), 32'h1);
    check("t6_refetch_addr", mif.mem_addr, 32'h0);

    // Random traffic over 0..0x3FC so lines alias between two tags
    rand_mode = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      flush    = ($urandom_range(0, 15) == 0);
      r        = 8'($urandom_range(0, 255));
      flush_pc = ($urandom_range(0, 49) == 0) ? 32'hFFFF_FFFC : {22'd0, r, 2'b00};
      stall_in = ($urandom_range(0, 3) == 0);
      pre_jmp_status = ($urandom_range(0, 3) == 0);
      r        = 8'($urandom_range(0, 255));
      pre_jmp_target = {22'd0, r, 2'b00};
      if ($urandom_range(0, 599) == 0) do_reset();
      else tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
